// File: rtl/link_rd_slave.sv
// Responder end of the 4-phase req/ack byte link (read direction).
// A local producer fills a small FIFO; each master req pops one byte onto data_out.
module link_rd_slave #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int BURST  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     req,
  output logic                     ack,
  output logic [DATA_W-1:0]        data_out,
  output logic                     last_byte,
  output logic                     stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(BURST - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [LW-1:0]     level_nxt;
  logic              accept;
  logic              pop;

  // Writes are gated by the registered full flag, so a same-cycle pop never frees room.
  assign accept = wr_en && !full;
  assign pop    = (state == S_IDLE) && req && (level != '0);

  always_comb begin
    level_nxt = level;
    if (accept && !pop)
      level_nxt = level + 1'b1;
    else if (!accept && pop)
      level_nxt = level - 1'b1;
  end

  // Storage carries no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ack       <= 1'b0;
      data_out  <= '0;
      last_byte <= 1'b0;
      stall     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (level != '0) begin
              data_out  <= mem[rd_ptr];
              last_byte <= (cnt == LAST_IDX);
              cnt       <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
              ack       <= 1'b1;
              stall     <= 1'b0;
              state     <= S_ACK;
            end else begin
              stall <= 1'b1;
            end
          end else begin
            stall <= 1'b0;
          end
        end
        S_ACK: begin
          stall <= 1'b0;
          if (!req) begin
            ack       <= 1'b0;
            last_byte <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_rd_slave.sv
// Scoreboard bench for link_rd_slave: accepted writes queue expected bytes,
// each completed handshake pops and compares them.
module tb_link_rd_slave;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int BURST  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [2:0]        level;
  logic              overflow;
  logic              req;
  logic              ack;
  logic [DATA_W-1:0] data_out;
  logic              last_byte;
  logic              stall;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] sb_q[$];
  int                m_cnt;
  logic              m_ovf;

  link_rd_slave #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .level(level), .overflow(overflow),
    .req(req), .ack(ack), .data_out(data_out),
    .last_byte(last_byte), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Producer write; the model decides acceptance from its own occupancy.
  task automatic write_byte(input logic [DATA_W-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en = 1'b0;
    if (sb_q.size() < DEPTH) sb_q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  // Full handshake against a non-empty FIFO: ack one edge after req, drop one edge after release.
  task automatic do_read(input string name);
    logic [DATA_W-1:0] exp_b;
    logic              exp_last;
    exp_b    = sb_q.pop_front();
    exp_last = (m_cnt == BURST - 1);
    m_cnt    = (m_cnt == BURST - 1) ? 0 : m_cnt + 1;
    req = 1'b1;
    step();
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL %s ack_rise: got %b expected 1", name, ack);
    end
    checks++;
    if (data_out !== exp_b) begin
      errors++;
      $display("FAIL %s data_out: got %h expected %h", name, data_out, exp_b);
    end
    checks++;
    if (last_byte !== exp_last) begin
      errors++;
      $display("FAIL %s last_byte: got %b expected %b", name, last_byte, exp_last);
    end
    checks++;
    if (level !== 3'(sb_q.size())) begin
      errors++;
      $display("FAIL %s level: got %0d expected %0d", name, level, sb_q.size());
    end
    step();
    checks++;
    if (ack !== 1'b1 || data_out !== exp_b) begin
      errors++;
      $display("FAIL %s ack_hold: got ack=%b data=%h expected ack=1 data=%h", name, ack, data_out, exp_b);
    end
    req = 1'b0;
    step();
    checks++;
    if (ack !== 1'b0 || last_byte !== 1'b0 || data_out !== exp_b) begin
      errors++;
      $display("FAIL %s ack_fall: got ack=%b last=%b data=%h expected ack=0 last=0 data=%h",
               name, ack, last_byte, data_out, exp_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; req = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({ack, data_out, level, full, overflow, last_byte, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b data=%h level=%0d full=%b ovf=%b last=%b stall=%b expected all 0",
               ack, data_out, level, full, overflow, last_byte, stall);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_read();
    write_byte(8'hA5);
    write_byte(8'h3C);
    checks++;
    if (level !== 3'd2) begin
      errors++;
      $display("FAIL basic_level: got %0d expected 2", level);
    end
    do_read("basic0");
    do_read("basic1");
  endtask

  task automatic test_stall();
    req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (ack !== 1'b0 || stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_empty[%0d]: got ack=%b stall=%b expected ack=0 stall=1", i, ack, stall);
      end
    end
    write_byte(8'h7E);
    checks++;
    if (stall !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL stall_persist: got ack=%b stall=%b expected ack=0 stall=1", ack, stall);
    end
    begin
      int waited = 0;
      while (ack !== 1'b1 && waited < 20) begin
        step();
        waited++;
      end
      checks++;
      if (waited != 1) begin
        errors++;
        $display("FAIL stall_release_latency: got %0d edges expected 1", waited);
      end
    end
    checks++;
    if (data_out !== sb_q[0] || stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got data=%h stall=%b expected data=%h stall=0", data_out, stall, sb_q[0]);
    end
    void'(sb_q.pop_front());
    m_cnt = (m_cnt == BURST - 1) ? 0 : m_cnt + 1;
    req = 1'b0;
    step();
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL stall_ack_fall: got %b expected 0", ack);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 4; i++) write_byte(8'(i));
    write_byte(8'hFF);
    checks++;
    if (full !== 1'b1 || level !== 3'd4 || overflow !== m_ovf || m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flags: got full=%b level=%0d ovf=%b expected full=1 level=4 ovf=1",
               full, level, overflow);
    end
    for (int i = 0; i < 4; i++) do_read("overflow_read");
    checks++;
    if (level !== 3'd0 || full !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_after: got level=%0d full=%b ovf=%b expected 0 0 1", level, full, overflow);
    end
  endtask

  task automatic test_burst();
    rst = 1'b0;
    #2;
    model_reset();
    rst = 1'b1;
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL burst_ovf_cleared: got %b expected 0", overflow);
    end
    for (int i = 0; i < 4; i++) write_byte(8'h10 + 8'(i));
    do_read("burst_r0");
    write_byte(8'h14);
    for (int i = 1; i < 5; i++) do_read("burst_rn");
  endtask

  task automatic test_reset_midway();
    for (int i = 0; i < 3; i++) write_byte(8'hC0 + 8'(i));
    req = 1'b1;
    step();
    checks++;
    if (ack !== 1'b1 || level !== 3'd2) begin
      errors++;
      $display("FAIL midrst_setup: got ack=%b level=%0d expected ack=1 level=2", ack, level);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL midrst_async: got ack=%b level=%0d expected ack=0 level=0", ack, level);
    end
    model_reset();
    #2;
    rst = 1'b1;
    step();
    checks++;
    if (stall !== 1'b1 || ack !== 1'b0) begin
      errors++;
      $display("FAIL midrst_stall: got stall=%b ack=%b expected stall=1 ack=0", stall, ack);
    end
    req = 1'b0;
    step();
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL abort_stall_clear: got %b expected 0", stall);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_stall();
    test_overflow();
    test_burst();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
